// File: rtl/mdio_master_ctrl.sv
// mdio_master_ctrl: Clause-22 MDIO master.
// Accepts a 32-bit frame word and generates MDC by dividing clk. It shifts out
// an optional all-ones preamble followed by the frame, MSB first. On read
// frames it releases MDIO from the TA field onward and captures the 16 data
// bits on rising MDC.
module mdio_master_ctrl #(
  parameter int CLK_DIV      = 4,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] t_data,
  input  logic        mdio_in,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  output logic [15:0] rd_data,
  output logic        data_rdy,
  output logic        busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam int PRE_LAST_I = (PREAMBLE_LEN > 0) ? (PREAMBLE_LEN - 1) : 0;
  localparam logic [4:0] PRE_LAST = 5'(PRE_LAST_I);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRE   = 2'd1;
  localparam logic [1:0] ST_FRAME = 2'd2;

  // Pad drive {oe, out} for frame bit idx: reads release the bus from TA down.
  function automatic logic [1:0] frame_drive(input logic [31:0] frame,
                                             input logic is_rd,
                                             input logic [4:0] idx);
    logic [1:0] r;
    if (is_rd && (idx <= 5'd17)) begin
      r = 2'b00;
    end else begin
      r = {1'b1, frame[idx]};
    end
    return r;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             mdc_q, mdc_d;
  logic [4:0]       bit_q, bit_d;
  logic [31:0]      frame_q, frame_d;
  logic             rd_q, rd_d;
  logic [15:0]      shift_q, shift_d;
  logic             out_q, out_d;
  logic             oe_q, oe_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;

  logic wrap_s, rise_s, fall_s, new_rd_s;

  assign wrap_s   = (div_q == DIV_LAST);
  assign rise_s   = wrap_s & ~mdc_q;
  assign fall_s   = wrap_s & mdc_q;
  assign new_rd_s = (t_data[29:28] == 2'b10);

  // Next-state logic: divider, bit sequencing, pad drive and read capture.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    mdc_d   = mdc_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    rd_d    = rd_q;
    shift_d = shift_q;
    out_d   = out_q;
    oe_d    = oe_q;
    rdata_d = rdata_q;
    rdy_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        div_d = '0;
        mdc_d = 1'b0;
        out_d = 1'b0;
        oe_d  = 1'b0;
        if (start) begin
          frame_d = t_data;
          rd_d    = new_rd_s;
          if (PREAMBLE_LEN > 0) begin
            state_d = ST_PRE;
            bit_d   = PRE_LAST;
            oe_d    = 1'b1;
            out_d   = 1'b1;
          end else begin
            state_d       = ST_FRAME;
            bit_d         = 5'd31;
            {oe_d, out_d} = frame_drive(t_data, new_rd_s, 5'd31);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRE, ST_FRAME: begin
        if (wrap_s) begin
          div_d = '0;
          mdc_d = ~mdc_q;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
        // Data bits 15..0 of a read are captured on rising MDC.
        if ((state_q == ST_FRAME) && rd_q && rise_s && (bit_q <= 5'd15)) begin
          shift_d = {shift_q[14:0], mdio_in};
        end else begin
          shift_d = shift_q;
        end
        // Bit boundaries sit on falling MDC.
        if (fall_s) begin
          if (bit_q == 5'd0) begin
            if (state_q == ST_PRE) begin
              state_d       = ST_FRAME;
              bit_d         = 5'd31;
              {oe_d, out_d} = frame_drive(frame_q, rd_q, 5'd31);
            end else begin
              state_d = ST_IDLE;
              div_d   = '0;
              mdc_d   = 1'b0;
              out_d   = 1'b0;
              oe_d    = 1'b0;
              if (rd_q) begin
                rdata_d = shift_q;
                rdy_d   = 1'b1;
              end else begin
                rdata_d = rdata_q;
              end
            end
          end else begin
            bit_d = bit_q - 5'd1;
            if (state_q == ST_PRE) begin
              oe_d  = 1'b1;
              out_d = 1'b1;
            end else begin
              {oe_d, out_d} = frame_drive(frame_q, rd_q, bit_q - 5'd1);
            end
          end
        end else begin
          bit_d = bit_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        div_d   = '0;
        mdc_d   = 1'b0;
        out_d   = 1'b0;
        oe_d    = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any transaction at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      mdc_q   <= 1'b0;
      bit_q   <= 5'd0;
      frame_q <= 32'h0000_0000;
      rd_q    <= 1'b0;
      shift_q <= 16'h0000;
      out_q   <= 1'b0;
      oe_q    <= 1'b0;
      rdata_q <= 16'h0000;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      mdc_q   <= mdc_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      rd_q    <= rd_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign mdc      = mdc_q;
  assign mdio_out = out_q;
  assign mdio_oe  = oe_q;
  assign rd_data  = rdata_q;
  assign data_rdy = rdy_q;
  assign busy     = busy_q;

endmodule

// File: doc/mdio_master_ctrl.md
# mdio_master_ctrl

Clause-22 MDIO management controller that sequences serial transactions on the MDIO bus toward the PHY-side peripheral. Accepts a 32-bit frame word from the host via a start handshake, generates MDC from the system clock, serializes preamble plus frame on MDIO, releases the bus for read turnaround, and captures 16 read-data bits. Sits between the host/register interface and the MDIO pads, tri-state buffer external.

## Interface
- CLK_DIV, 4, clk cycles per MDC half-period; legal range ≥1; bit period = 2*CLK_DIV cycles
- PREAMBLE_LEN, 32, preamble bits (all 1) before ST; legal range 0..32; 0 = preamble suppression
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low; one clock, no other clocks
- start  input  1  transaction request, sampled only while busy=0
- t_data  input  32  frame word: [31:30] ST, [29:28] OP, [27:23] PHYAD, [22:18] REGAD, [17:16] TA, [15:0] DATA
- mdio_in  input  1  MDIO pad input
- mdc  output  1  management clock
- mdio_out  output  1  MDIO drive value
- mdio_oe  output  1  MDIO output enable (1 = controller drives)
- rd_data  output  16  last read data, MSB first as received
- data_rdy  output  1  one-cycle pulse, read complete
- busy  output  1  transaction in progress

## Operation
- States: IDLE, PREAMBLE, FRAME. IDLE→PREAMBLE (or FRAME if PREAMBLE_LEN=0) on start & !busy; PREAMBLE→FRAME after PREAMBLE_LEN bits; FRAME→IDLE after bit 0 completes.
- On accept: t_data latched; later t_data changes ignored. Read iff t_data[29:28]==2'b10; every other OP is a write (all 32 bits driven).
- Divider div_cnt counts 0..CLK_DIV-1 while busy; at CLK_DIV-1 it wraps and mdc toggles. Idle: div_cnt=0, mdc=0.
- Each bit occupies one bit period starting at mdc low phase: mdio_out updated at the clk edge where mdc falls (first bit: at accept), held through the rising edge.
- PREAMBLE: mdio_oe=1, mdio_out=1.
- FRAME, write: bits 31..0 driven MSB first, mdio_oe=1.
- FRAME, read: bits 31..18 driven, mdio_oe=1; bits 17..0 mdio_oe=0, mdio_out=0.
- Read sampling: for bits 15..0, mdio_in registered at the clk edge where mdc rises; shifted into internal register, MSB first.
- Completion: rd_data updated with the 16 samples and data_rdy=1 for exactly one cycle (reads only); rd_data holds until next read completes; writes leave rd_data unchanged.
- start while busy=1 ignored (no queueing). start in the cycle busy returns to 0 accepted normally (back-to-back).

## Timing
- Reset values: mdc=0, mdio_out=0, mdio_oe=0, rd_data=16'h0000, data_rdy=0, busy=0; state=IDLE. Reset assertion mid-transaction aborts immediately (asynchronously), no data_rdy.
- Cycle N: start=1, busy=0 sampled. Cycle N+1: busy=1, mdio_oe=1, mdio_out=first bit, mdc=0.
- mdc first rises at N+1+CLK_DIV, falls at N+1+2*CLK_DIV.
- busy high for exactly (PREAMBLE_LEN+32)*2*CLK_DIV cycles; default 512.
- Cycle after last bit period: busy=0, mdc=0, mdio_oe=0, mdio_out=0, data_rdy=1 (read).
- Read data latency from bit-0 rising mdc sample to data_rdy: CLK_DIV cycles.
- mdc duty 50%, never glitches; no mdc edges while idle.

## Test plan
- Reset: hold reset=0 5 cycles with start toggling -> all outputs at reset values, no mdc edges.
- Write, defaults: t_data=32'h508A_A5A5, start one cycle -> 32 ones then bits 508AA5A5 MSB first, each stable across mdc rise, mdio_oe=1 throughout, busy 512 cycles, no data_rdy, rd_data unchanged.
- Read: t_data=32'h6190_0000, PHY model drives 16'h1234 after TA -> mdio_oe falls after bit 18 (14 frame bits), rd_data=16'h1234, data_rdy single pulse as busy falls.
- Start during busy: second start with t_data=32'hFFFF_FFFF mid-preamble -> ignored, original frame completes unchanged, busy length 512.
- Reset mid-read at frame bit 10 -> outputs immediately at reset values, no data_rdy; following read of 16'hBEEF completes correctly.
- CLK_DIV=1, PREAMBLE_LEN=0: back-to-back reads of 16'h0001 then 16'h8000 -> no preamble, busy 64 cycles each, one idle cycle between, both data_rdy pulses with correct rd_data.
